stage4_sum_buffer: RTL and testbench
====================================

# stage4_sum_buffer

Softmax stage 4: consumes the Q4.12 2^x values produced by the pow2 approximation stage and accumulates one vector (frame) of them into an exact wide sum. It buffers every element of the frame, then replays the buffered elements each paired with the frame total. The normalisation (divide) stage downstream receives element and denominator together. It sits between stage3 (pow2 approx) and the stage5 divider.

## Interface
- N, 64: maximum frame length (elements); power of two, ≥2.
- AW, $clog2(N): buffer address width (derived; not overridden).
- SW, 16+AW: sum width, unsigned Q(4+AW).12.
- clk  in  1  single clock, rising edge.
- rst  in  1  one clock; reset is asynchronous and active-low.
- en  in  1  global pipeline enable; when 0, all state and outputs hold.
- valid_in  in  1  in_pow carries a frame element.
- last_in  in  1  qualifies the final element of a frame (meaningful only with valid_in).
- in_pow  in  16  2^x, unsigned Q4.12.
- ready_in  out  1  1 in ACCUM, 0 in DRAIN; upstream control stalls stage3 when low.
- valid_out  out  1  pow_out/sum_out valid.
- pow_out  out  16  buffered element, unsigned Q4.12.
- sum_out  out  SW  frame total, constant across the whole drain.
- last_out  out  1  marks the final replayed element.
- err_drop  out  1  sticky: valid_in seen while ready_in=0.
- err_len  out  1  sticky: frame reached N elements without last_in.

## Operation
- States: ACCUM (reset state), DRAIN.
- Accept = en & valid_in & (state==ACCUM).
- ACCUM, on accept: buf[wr_ptr]<=in_pow; acc<=acc+in_pow (zero-extended to SW, no saturation, cannot overflow); wr_ptr++.
- Frame end = accept & (last_in | wr_ptr==N-1). On frame end: sum_total<=acc+in_pow; count<=wr_ptr+1; acc<=0; wr_ptr<=0; rd_ptr<=0; state<=DRAIN.
- If wr_ptr==N-1 & !last_in at frame end: err_len<=1; the frame is still closed at N elements.
- DRAIN, each en cycle: register pow_out<=buf[rd_ptr], sum_out<=sum_total, valid_out<=1, last_out<=(rd_ptr==count-1); rd_ptr++. When rd_ptr==count-1, state<=ACCUM.
- ACCUM with no accept: valid_out<=0, last_out<=0; pow_out/sum_out hold their last values.
- en & valid_in & state==DRAIN: the element is discarded, the buffer and acc are untouched, err_drop<=1.
- err_drop and err_len are cleared only by reset.
- Reset (asserted at any time, including mid-frame or mid-drain): state=ACCUM, acc/sum_total/count/pointers=0, all outputs 0 except ready_in=1. The partial frame is lost.

## Timing
- ready_in is a combinational decode of state; every other output is registered.
- Frame end accepted at edge k: ready_in falls after edge k.
- Drain outputs: elements 0..count-1 appear after edges k+1..k+count, with last_out on the element after edge k+count. The state returns to ACCUM at that edge, and ready_in=1 from then on.
- A new frame may be accepted at edge k+count+1. Frame-end-to-first-output latency is 1 enabled cycle.
- Each en=0 cycle extends every interval above by one cycle. The outputs are frozen during those cycles, so valid_out may stay high.
- Single-element frame: count=1. One output beat carries valid_out=last_out=1, and sum_out equals that element.

## Structure
- Shared package softmax_pkg:
  - Q412_W=16 and Q412_FRAC=12.
  - Stage-4 state typedef {ACCUM, DRAIN}.
  - A reusable sum-width function (16+$clog2(N)).
- Sub-module sum_buf_ram: N x 16 register array, one synchronous write port, one read port registered into pow_out. It has no reset on its contents.
- Pointers, acc, FSM, error flags and output registers live in stage4_sum_buffer.

## Test plan
- Frame 0x1000,0x0800,0x0400,last: ready_in falls after the 3rd accept; 3 beats of pow_out 0x1000/0x0800/0x0400, each with sum_out=0x1C00; last_out only on the 3rd beat.
- N=64 frame of 64×0xFFFF without last_in: err_len=1; drain of 64 beats with sum_out=0x3FFFC0 (64×65535, 22 bits).
- Single element 0x0200 with last_in: 1 beat, valid_out=last_out=1, sum_out=0x0200.
- valid_in held high during DRAIN: err_drop=1; drained values unchanged; the next frame's sum excludes the dropped data.
- en toggled 0/1 during accumulate and drain: outputs freeze while en=0; sequence and sums are identical to the en=1 run.
- rst asserted mid-drain (asynchronously, between edges): outputs go to 0 immediately, ready_in=1; the next frame 0x1000,last yields sum_out=0x1000.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax pipeline stages.
//   Q412_W / Q412_FRAC : width and fraction bits of the unsigned Q4.12 element format.
//   stage4_state_e     : stage-4 accumulate/drain state.
//   sum_width()        : width needed to sum n Q4.12 values exactly.
package softmax_pkg;

  localparam int unsigned Q412_W    = 16;
  localparam int unsigned Q412_FRAC = 12;

  typedef enum logic {
    StAccum,
    StDrain
  } stage4_state_e;

  // Exact sum of n unsigned Q412_W-bit values needs $clog2(n) extra integer bits.
  function automatic int unsigned sum_width(input int unsigned n);
    return Q412_W + $clog2(n);
  endfunction

endpackage

// File: rtl/sum_buf_ram.sv
// Frame element buffer for stage 4.
// Depth x Q412_W register array with one synchronous write port and one read port whose
// data is registered (the register is the stage's pow_out). Array contents have no reset;
// only the read register is reset.
//   clk_i, rst_ni : clock, asynchronous active-low reset (read register only)
//   we_i, waddr_i, wdata_i : write port
//   re_i, raddr_i : read strobe and address; rdata_o updates only when re_i=1
//   rdata_o : registered read data
module sum_buf_ram
  import softmax_pkg::*;
#(
  parameter int unsigned Depth = 64,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [Aw-1:0]     waddr_i,
  input  logic [Q412_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [Aw-1:0]     raddr_i,
  output logic [Q412_W-1:0] rdata_o
);

  logic [Q412_W-1:0] mem_q [Depth];
  logic [Q412_W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register holds its value between reads so the last beat stays visible.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stage4_sum_buffer.sv
// Softmax stage 4: accumulates one frame of Q4.12 2^x values into an exact wide sum while
// buffering every element, then replays the elements each paired with the frame total.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : global pipeline enable; all state and outputs hold when 0
//   valid_in, last_in, in_pow : element input (last_in closes the frame)
//   ready_in   : 1 while accumulating, 0 while draining (combinational from state)
//   valid_out, pow_out, sum_out, last_out : replayed element, frame total, final-beat flag
//   err_drop   : sticky, element offered while draining
//   err_len    : sticky, frame closed at N elements without last_in
module stage4_sum_buffer
  import softmax_pkg::*;
#(
  parameter int unsigned N   = 64,
  localparam int unsigned AW = $clog2(N),
  localparam int unsigned SW = sum_width(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              valid_in,
  input  logic              last_in,
  input  logic [Q412_W-1:0] in_pow,
  output logic              ready_in,
  output logic              valid_out,
  output logic [Q412_W-1:0] pow_out,
  output logic [SW-1:0]     sum_out,
  output logic              last_out,
  output logic              err_drop,
  output logic              err_len
);

  stage4_state_e state_d, state_q;
  logic [SW-1:0] acc_d, acc_q;
  logic [SW-1:0] sum_total_d, sum_total_q;
  logic [AW:0]   count_d, count_q;  // up to N, one bit wider than the pointers
  logic [AW-1:0] wr_ptr_d, wr_ptr_q;
  logic [AW-1:0] rd_ptr_d, rd_ptr_q;
  logic [SW-1:0] sum_out_d, sum_out_q;
  logic          valid_out_d, valid_out_q;
  logic          last_out_d, last_out_q;
  logic          err_drop_d, err_drop_q;
  logic          err_len_d, err_len_q;

  logic          ram_we;
  logic          ram_re;
  logic [SW-1:0] in_ext;
  logic [SW-1:0] acc_sum;
  logic          wr_full;
  logic          rd_is_last;

  assign in_ext     = SW'(in_pow);
  assign acc_sum    = acc_q + in_ext;
  assign wr_full    = (wr_ptr_q == AW'(N - 1));
  assign rd_is_last = ({1'b0, rd_ptr_q} == (count_q - 1'b1));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sum_total_d = sum_total_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    sum_out_d   = sum_out_q;
    valid_out_d = valid_out_q;
    last_out_d  = last_out_q;
    err_drop_d  = err_drop_q;
    err_len_d   = err_len_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;

    if (en) begin
      unique case (state_q)
        StAccum: begin
          valid_out_d = 1'b0;
          last_out_d  = 1'b0;
          if (valid_in) begin
            ram_we   = 1'b1;
            acc_d    = acc_sum;
            wr_ptr_d = wr_ptr_q + 1'b1;
            // A full buffer closes the frame even without last_in.
            if (last_in || wr_full) begin
              sum_total_d = acc_sum;
              count_d     = {1'b0, wr_ptr_q} + 1'b1;
              acc_d       = '0;
              wr_ptr_d    = '0;
              rd_ptr_d    = '0;
              state_d     = StDrain;
              if (!last_in) begin
                err_len_d = 1'b1;
              end
            end
          end
        end
        StDrain: begin
          ram_re      = 1'b1;
          sum_out_d   = sum_total_q;
          valid_out_d = 1'b1;
          last_out_d  = rd_is_last;
          rd_ptr_d    = rd_ptr_q + 1'b1;
          if (rd_is_last) begin
            state_d = StAccum;
          end
          // Offered data is discarded; buffer and acc are untouched.
          if (valid_in) begin
            err_drop_d = 1'b1;
          end
        end
        default: state_d = StAccum;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAccum;
      acc_q       <= '0;
      sum_total_q <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      sum_out_q   <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      err_drop_q  <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sum_total_q <= sum_total_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      sum_out_q   <= sum_out_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
      err_drop_q  <= err_drop_d;
      err_len_q   <= err_len_d;
    end
  end

  sum_buf_ram #(
    .Depth (N)
  ) u_sum_buf_ram (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_pow),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (pow_out)
  );

  assign ready_in  = (state_q == StAccum);
  assign valid_out = valid_out_q;
  assign sum_out   = sum_out_q;
  assign last_out  = last_out_q;
  assign err_drop  = err_drop_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_stage4_sum_buffer.sv
// Self-checking bench for stage4_sum_buffer: directed frames from the test plan plus
// randomized frames, all compared against a queue-based frame model.
module tb_stage4_sum_buffer;

  localparam int unsigned N  = 64;
  localparam int unsigned SW = 16 + $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          valid_in = 1'b0;
  logic          last_in = 1'b0;
  logic [15:0]   in_pow = '0;
  logic          ready_in;
  logic          valid_out;
  logic [15:0]   pow_out;
  logic [SW-1:0] sum_out;
  logic          last_out;
  logic          err_drop;
  logic          err_len;

  int n_checks = 0;
  int n_errors = 0;
  bit en_rand  = 1'b0;
  bit en_seen  = 1'b0;

  stage4_sum_buffer #(
    .N (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .valid_in  (valid_in),
    .last_in   (last_in),
    .in_pow    (in_pow),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .pow_out   (pow_out),
    .sum_out   (sum_out),
    .last_out  (last_out),
    .err_drop  (err_drop),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Frame-level reference model: collect accepted elements, total them when the frame
  // closes, then hand them out one per enabled cycle.
  logic [15:0]   m_buf[$];
  int            m_rd;
  bit            m_drain;
  int unsigned   m_total;
  logic          exp_valid, exp_last, exp_drop, exp_len;
  logic [15:0]   exp_pow;
  logic [SW-1:0] exp_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_buf.delete();
      m_rd = 0; m_drain = 0; m_total = 0;
      exp_valid = 0; exp_last = 0; exp_drop = 0; exp_len = 0;
      exp_pow = '0; exp_sum = '0;
    end else if (en) begin
      if (m_drain) begin
        if (valid_in) exp_drop = 1'b1;
        exp_pow   = m_buf[m_rd];
        exp_sum   = SW'(m_total);
        exp_valid = 1'b1;
        exp_last  = (m_rd == m_buf.size() - 1);
        m_rd++;
        if (exp_last) begin
          m_drain = 0;
          m_buf.delete();
        end
      end else begin
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        if (valid_in) begin
          m_buf.push_back(in_pow);
          if (last_in || m_buf.size() == N) begin
            if (!last_in) exp_len = 1'b1;
            m_total = 0;
            foreach (m_buf[i]) m_total += m_buf[i];
            m_drain = 1;
            m_rd    = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("ready_in", ready_in, !m_drain);
      check_eq("valid_out", valid_out, exp_valid);
      check_eq("last_out", last_out, exp_last);
      check_eq("pow_out", pow_out, exp_pow);
      check_eq("sum_out", sum_out, exp_sum);
      check_eq("err_drop", err_drop, exp_drop);
      check_eq("err_len", err_len, exp_len);
    end
  end

  // Beat monitor: records each newly produced output beat (enabled edge only).
  logic [15:0]   obs_pow[$];
  logic [SW-1:0] obs_sum[$];
  logic          obs_last[$];
  logic [15:0]   ev[$];

  always @(posedge clk) en_seen = en;

  always @(negedge clk) begin
    if (rst_n && en_seen && valid_out) begin
      obs_pow.push_back(pow_out);
      obs_sum.push_back(sum_out);
      obs_last.push_back(last_out);
    end
  end

  task automatic clear_obs();
    obs_pow.delete();
    obs_sum.delete();
    obs_last.delete();
  endtask

  task automatic step();
    @(negedge clk);
    en = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      valid_in = 1'b0;
      last_in  = 1'b0;
    end
  endtask

  // Hold the element until an enabled cycle in ACCUM takes it.
  task automatic send(input logic [15:0] v, input bit lst);
    bit done = 1'b0;
    int guard = 0;
    while (!done && guard < 2000) begin
      step();
      valid_in = 1'b1;
      in_pow   = v;
      last_in  = lst;
      done     = en && ready_in;
      guard++;
    end
    if (!done) check_eq("send_timeout", 0, 1);
  endtask

  // Wait for the drain to finish, optionally offering junk the whole time.
  task automatic wait_drain(input bit junk);
    bit done = 1'b0;
    int guard = 0;
    while (!done && guard < 4000) begin
      step();
      if (ready_in) begin
        valid_in = 1'b0;
        last_in  = 1'b0;
        done     = 1'b1;
      end else begin
        valid_in = junk;
        in_pow   = 16'($urandom);
        last_in  = 1'($urandom_range(0, 1));
      end
      guard++;
    end
    valid_in = 1'b0;
    if (!done) check_eq("drain_timeout", 0, 1);
  endtask

  // Compare recorded beats against the element list in ev and a fixed total.
  task automatic check_frame(input string tag, input logic [SW-1:0] es);
    int n;
    idle(2);
    check_eq({tag, "_beats"}, obs_pow.size(), ev.size());
    n = (obs_pow.size() < ev.size()) ? obs_pow.size() : ev.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_pow"}, obs_pow[i], ev[i]);
      check_eq({tag, "_sum"}, obs_sum[i], es);
      check_eq({tag, "_last"}, obs_last[i], (i == ev.size() - 1));
    end
    clear_obs();
  endtask

  initial begin
    #12;
    check_eq("rst_ready", ready_in, 1);
    check_eq("rst_valid", valid_out, 0);
    check_eq("rst_pow", pow_out, 0);
    check_eq("rst_sum", sum_out, 0);
    check_eq("rst_last", last_out, 0);
    check_eq("rst_errs", {err_drop, err_len}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    clear_obs();

    // Three-element frame.
    send(16'h1000, 0);
    send(16'h0800, 0);
    send(16'h0400, 1);
    step();
    valid_in = 1'b0;
    last_in  = 1'b0;
    check_eq("ready_low_after_last", ready_in, 0);
    wait_drain(0);
    ev.delete(); ev.push_back(16'h1000); ev.push_back(16'h0800); ev.push_back(16'h0400);
    check_frame("frame3", 22'h1C00);

    // Single-element frame.
    send(16'h0200, 1);
    wait_drain(0);
    ev.delete(); ev.push_back(16'h0200);
    check_frame("single", 22'h0200);
    check_eq("err_len_clear", err_len, 0);

    // Full frame without last_in.
    ev.delete();
    for (int i = 0; i < N; i++) begin
      send(16'hFFFF, 0);
      ev.push_back(16'hFFFF);
    end
    wait_drain(0);
    check_eq("err_len_set", err_len, 1);
    check_frame("full", 22'h3FFFC0);

    // Junk offered during drain is dropped and flagged.
    check_eq("err_drop_clear", err_drop, 0);
    send(16'h0100, 0);
    send(16'h0200, 1);
    wait_drain(1);
    check_eq("err_drop_set", err_drop, 1);
    ev.delete(); ev.push_back(16'h0100); ev.push_back(16'h0200);
    check_frame("drop", 22'h0300);
    send(16'h0300, 1);
    wait_drain(0);
    ev.delete(); ev.push_back(16'h0300);
    check_frame("after_drop", 22'h0300);

    // Same three-element frame with en toggling.
    en_rand = 1'b1;
    send(16'h1000, 0);
    send(16'h0800, 0);
    send(16'h0400, 1);
    wait_drain(0);
    ev.delete(); ev.push_back(16'h1000); ev.push_back(16'h0800); ev.push_back(16'h0400);
    check_frame("en_toggle", 22'h1C00);

    // Random frames, checked cycle by cycle against the model.
    for (int f = 0; f < 20; f++) begin
      int  len;
      bit  omit;
      omit = ($urandom_range(0, 7) == 0);
      len  = omit ? N : $urandom_range(1, N);
      for (int i = 0; i < len; i++) begin
        send(16'($urandom), (i == len - 1) && !omit);
      end
      wait_drain(1'($urandom_range(0, 1)));
    end
    en_rand = 1'b0;
    idle(2);
    clear_obs();

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 5; i++) send(16'h0111 * 16'(i + 1), i == 4);
    idle(2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", valid_out, 0);
    check_eq("arst_pow", pow_out, 0);
    check_eq("arst_sum", sum_out, 0);
    check_eq("arst_last", last_out, 0);
    check_eq("arst_ready", ready_in, 1);
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    send(16'h1000, 1);
    wait_drain(0);
    ev.delete(); ev.push_back(16'h1000);
    check_frame("post_rst", 22'h1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
